// File: rtl/vm_proj_reader.sv
// Walks six VM bins in order, issuing credit-limited reads on a shared address
// bus, and returns the tagged read data through a small show-ahead FIFO.
module vm_proj_reader #(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [8:0]  nent_phi1z1,
  input  logic [8:0]  nent_phi1z2,
  input  logic [8:0]  nent_phi2z1,
  input  logic [8:0]  nent_phi2z2,
  input  logic [8:0]  nent_phi3z1,
  input  logic [8:0]  nent_phi3z2,
  output logic [8:0]  rd_add,
  output logic        rd_en_phi1z1,
  output logic        rd_en_phi1z2,
  output logic        rd_en_phi2z1,
  output logic        rd_en_phi2z2,
  output logic        rd_en_phi3z1,
  output logic        rd_en_phi3z2,
  input  logic [12:0] rd_data_phi1z1,
  input  logic [12:0] rd_data_phi1z2,
  input  logic [12:0] rd_data_phi2z1,
  input  logic [12:0] rd_data_phi2z2,
  input  logic [12:0] rd_data_phi3z1,
  input  logic [12:0] rd_data_phi3z2,
  output logic [12:0] vm_projection_out,
  output logic [2:0]  out_bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam int NB = 6;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [8:0]            nent_in [NB];
  logic [12:0]           rd_data_in [NB];
  logic [8:0]            cnt_q [NB], cnt_d [NB];
  logic [2:0]            bin_q, bin_d;
  logic [8:0]            addr_q, addr_d;
  logic                  more_q, more_d;
  logic [NB-1:0]         rd_en_q, rd_en_d;
  logic [2:0]            rd_bin_q, rd_bin_d;
  logic [8:0]            rd_add_q, rd_add_d;
  logic [RD_LATENCY-1:0] sr_vld_q, sr_vld_d;
  logic [2:0]            sr_bin_q [RD_LATENCY], sr_bin_d [RD_LATENCY];
  logic [EW-1:0]         fifo_q [FIFO_DEPTH], fifo_d [FIFO_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;

  logic                  capture, pop, credit_ok, issue_ok, eff_more;
  logic [2:0]            cap_bin, eff_bin;
  logic [8:0]            eff_addr;
  logic [8:0]            eff_cnt [NB];
  logic [CW-1:0]         wr_idx;
  int                    inflight_d;

  assign nent_in    = '{nent_phi1z1, nent_phi1z2, nent_phi2z1, nent_phi2z2, nent_phi3z1, nent_phi3z2};
  assign rd_data_in = '{rd_data_phi1z1, rd_data_phi1z2, rd_data_phi2z1,
                        rd_data_phi2z2, rd_data_phi3z1, rd_data_phi3z2};

  // Return path: in-flight tag pipe feeding a shift FIFO whose entry 0 is the head.
  always_comb begin
    capture     = sr_vld_q[RD_LATENCY-1];
    cap_bin     = sr_bin_q[RD_LATENCY-1];
    pop         = out_valid_q & out_ready;
    sr_vld_d[0] = |rd_en_q;
    sr_bin_d[0] = rd_bin_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sr_vld_d[i] = sr_vld_q[i-1];
      sr_bin_d[i] = sr_bin_q[i-1];
    end
    inflight_d = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_d = inflight_d + (sr_vld_d[i] ? 1 : 0);
    end
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      fifo_d[i] = pop ? fifo_q[i+1] : fifo_q[i];
    end
    fifo_d[FIFO_DEPTH-1] = pop ? '0 : fifo_q[FIFO_DEPTH-1];
    wr_idx = count_q - CW'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (capture && (CW'(i) == wr_idx)) fifo_d[i] = {cap_bin, rd_data_in[cap_bin]};
    end
    count_d     = count_q + CW'(capture) - CW'(pop);
    out_valid_d = (count_d != '0);
    // Credit is judged on the occupancy the next (issuing) cycle will start with.
    credit_ok   = (int'(count_d) + inflight_d) < FIFO_DEPTH;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    addr_d   = addr_q;
    more_d   = more_q;
    rd_en_d  = '0;
    rd_bin_d = rd_bin_q;
    rd_add_d = rd_add_q;
    eff_cnt  = cnt_q;
    eff_bin  = bin_q;
    eff_addr = addr_q;
    eff_more = more_q;
    issue_ok = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          eff_cnt  = nent_in;
          eff_bin  = '0;
          eff_addr = '0;
          eff_more = 1'b0;
          for (int i = NB - 1; i >= 0; i--) begin
            if (nent_in[i] != '0) begin
              eff_bin  = 3'(i);
              eff_more = 1'b1;
            end
          end
          cnt_d    = nent_in;
          bin_d    = eff_bin;
          addr_d   = '0;
          more_d   = eff_more;
          issue_ok = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!more_q) state_d = S_DRAIN;
        else         issue_ok = 1'b1;
      end
      S_DRAIN: begin
        if (sr_vld_q == '0 && count_q == '0 && !capture) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Register the read for the next cycle and advance past empty bins in the same step.
    if (issue_ok && eff_more && credit_ok) begin
      rd_en_d[eff_bin] = 1'b1;
      rd_bin_d         = eff_bin;
      rd_add_d         = eff_addr;
      if (({1'b0, eff_addr} + 10'd1) < {1'b0, eff_cnt[eff_bin]}) begin
        addr_d = eff_addr + 9'd1;
      end else begin
        addr_d = '0;
        more_d = 1'b0;
        for (int i = NB - 1; i >= 0; i--) begin
          if ((3'(i) > eff_bin) && (eff_cnt[i] != '0)) begin
            bin_d  = 3'(i);
            more_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      bin_q       <= '0;
      addr_q      <= '0;
      more_q      <= 1'b0;
      rd_en_q     <= '0;
      rd_bin_q    <= '0;
      rd_add_q    <= '0;
      sr_vld_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) sr_bin_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      addr_q      <= addr_d;
      more_q      <= more_d;
      rd_en_q     <= rd_en_d;
      rd_bin_q    <= rd_bin_d;
      rd_add_q    <= rd_add_d;
      sr_vld_q    <= sr_vld_d;
      sr_bin_q    <= sr_bin_d;
      fifo_q      <= fifo_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_add            = rd_add_q;
  assign rd_en_phi1z1      = rd_en_q[0];
  assign rd_en_phi1z2      = rd_en_q[1];
  assign rd_en_phi2z1      = rd_en_q[2];
  assign rd_en_phi2z2      = rd_en_q[3];
  assign rd_en_phi3z1      = rd_en_q[4];
  assign rd_en_phi3z2      = rd_en_q[5];
  assign vm_projection_out = fifo_q[0][12:0];
  assign out_bin           = fifo_q[0][15:13];
  assign out_valid         = out_valid_q;
  assign busy              = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done              = (state_q == S_DONE);
endmodule

// File: tb/tb_vm_proj_reader.sv
// Directed event table for vm_proj_reader against a two-stage VM memory model,
// plus hand-written reset-abort and restart-while-busy sequences.
module tb_vm_proj_reader;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [8:0]  nent_drv [6];
  logic [8:0]  rd_add;
  logic        rd_en_0, rd_en_1, rd_en_2, rd_en_3, rd_en_4, rd_en_5;
  logic [5:0]  rd_en_vec;
  logic [12:0] mem_out [6];
  logic [12:0] vm_projection_out;
  logic [2:0]  out_bin;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int errors   = 0;
  int n_checks = 0;

  typedef struct packed {
    logic [5:0][8:0] nent;
    int ready_low;
    int exp_first_rd;
    int exp_first_vld;
    int exp_done;
    int exp_busy;
    int exp_stall;
  } vec_t;

  vec_t vecs [6];

  vm_proj_reader #(.RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .nent_phi1z1(nent_drv[0]), .nent_phi1z2(nent_drv[1]), .nent_phi2z1(nent_drv[2]),
    .nent_phi2z2(nent_drv[3]), .nent_phi3z1(nent_drv[4]), .nent_phi3z2(nent_drv[5]),
    .rd_add(rd_add),
    .rd_en_phi1z1(rd_en_0), .rd_en_phi1z2(rd_en_1), .rd_en_phi2z1(rd_en_2),
    .rd_en_phi2z2(rd_en_3), .rd_en_phi3z1(rd_en_4), .rd_en_phi3z2(rd_en_5),
    .rd_data_phi1z1(mem_out[0]), .rd_data_phi1z2(mem_out[1]), .rd_data_phi2z1(mem_out[2]),
    .rd_data_phi2z2(mem_out[3]), .rd_data_phi3z1(mem_out[4]), .rd_data_phi3z2(mem_out[5]),
    .vm_projection_out(vm_projection_out), .out_bin(out_bin), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  assign rd_en_vec = {rd_en_5, rd_en_4, rd_en_3, rd_en_2, rd_en_1, rd_en_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mem_word(input int b, input int a);
    logic [12:0] w;
    w = {6'(a), 3'(b), (4'(a >> 6) ^ 4'(b))};
    return w;
  endfunction

  // Memory model: address registered, data one cycle later; unread bins return poison.
  logic [5:0] s1_en;
  logic [8:0] s1_add;
  always @(posedge clk) begin
    s1_en  <= rd_en_vec;
    s1_add <= rd_add;
    for (int i = 0; i < 6; i++) begin
      mem_out[i] <= s1_en[i] ? mem_word(i, int'(s1_add)) : 13'h1FFF;
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input int rl, input int fr,
                              input int fv, input int dn, input int bz, input int st);
    vec_t v;
    v.nent          = {9'(c5), 9'(c4), 9'(c3), 9'(c2), 9'(c1), 9'(c0)};
    v.ready_low     = rl;
    v.exp_first_rd  = fr;
    v.exp_first_vld = fv;
    v.exp_done      = dn;
    v.exp_busy      = bz;
    v.exp_stall     = st;
    return v;
  endfunction

  task automatic run_event(input vec_t v, input int id);
    int exp_b[$];
    int exp_a[$];
    int total = 0, n = 0, issued = 0, delivered = 0;
    int first_rd = 0, last_rd = 0, first_vld = 0, done_cyc = 0, done_cnt = 0;
    int busy_cnt = 0, multi = 0, bin_seen;
    for (int b = 0; b < 6; b++) begin
      for (int a = 0; a < int'(v.nent[b]); a++) begin
        exp_b.push_back(b);
        exp_a.push_back(a);
      end
    end
    total = exp_b.size();

    @(negedge clk);
    for (int b = 0; b < 6; b++) nent_drv[b] = v.nent[b];
    start     = 1'b1;
    out_ready = (v.ready_low == 0);
    while (1) begin
      @(negedge clk);
      n++;
      start     = (n == 2);
      out_ready = (n > v.ready_low);
      if (n == 1) begin
        for (int b = 0; b < 6; b++) nent_drv[b] = 9'(9'h1F0 + b);
      end
      if ($countones(rd_en_vec) > 1) multi++;
      if ($countones(rd_en_vec) == 1) begin
        bin_seen = 0;
        for (int b = 0; b < 6; b++) if (rd_en_vec[b]) bin_seen = b;
        if (issued < total)
          check("issue_bin_addr", bin_seen * 1000 + int'(rd_add),
                exp_b[issued] * 1000 + exp_a[issued]);
        else
          check("extra_issue", issued + 1, total);
        if (first_rd == 0) first_rd = n;
        last_rd = n;
        issued++;
      end
      if (out_valid && first_vld == 0) first_vld = n;
      if (out_valid && out_ready) begin
        if (delivered < total)
          check("out_bin_data", int'(out_bin) * 10000 + int'(vm_projection_out),
                exp_b[delivered] * 10000 + int'(mem_word(exp_b[delivered], exp_a[delivered])));
        else
          check("extra_output", delivered + 1, total);
        delivered++;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (v.ready_low > 0 && n == v.ready_low)
        check("stall_occ_plus_inflight", issued - delivered, v.exp_stall);
      if (done_cyc != 0 && n >= done_cyc + 3) break;
      if (n >= 1000) break;
    end
    start = 1'b0;
    out_ready = 1'b1;

    check("done_cycle", done_cyc, v.exp_done);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("first_rd_cycle", first_rd, v.exp_first_rd);
    check("first_valid_cycle", first_vld, v.exp_first_vld);
    check("issued_count", issued, total);
    check("delivered_count", delivered, total);
    check("multi_rd_en", multi, 0);
    if (v.ready_low == 0 && total > 0)
      check("issue_back_to_back", last_rd - first_rd + 1, total);
    $display("event %0d: entries=%0d issued=%0d delivered=%0d done@T+%0d busy=%0d",
             id, total, issued, delivered, done_cyc, busy_cnt);
  endtask

  initial begin
    int stale;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) nent_drv[b] = '0;

    //          c0  c1 c2  c3 c4  c5  rl  fr fv  dn   bz  st
    vecs[0] = mk(3,  0, 0,  0, 0,  0,  0,  1, 4,   8,   7, 0);
    vecs[1] = mk(0,  0, 0,  0, 0,  0,  0,  0, 0,   3,   2, 0);
    vecs[2] = mk(0,  2, 0,  0, 0,  2,  0,  1, 4,   9,   8, 0);
    vecs[3] = mk(0,  0, 10, 0, 0,  0, 20,  1, 4,  32,  31, 4);
    vecs[4] = mk(1,  0, 0,  3, 1,  0,  0,  1, 4,  10,   9, 0);
    vecs[5] = mk(0,  0, 0,  0, 0, 511, 0,  1, 4, 516, 515, 0);

    repeat (3) @(negedge clk);
    check("reset_rd_add", int'(rd_add), 0);
    check("reset_rd_en", int'(rd_en_vec), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(vm_projection_out), 0);
    check("reset_out_bin", int'(out_bin), 0);
    check("reset_busy_done", int'({busy, done}), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_event(vecs[i], i);

    // Abort a 5-entry event mid-issue, with data already in the FIFO.
    @(negedge clk);
    for (int b = 0; b < 6; b++) nent_drv[b] = '0;
    nent_drv[0] = 9'd5;
    start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_reset_valid", int'(out_valid), 1);
    check("pre_reset_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(vm_projection_out), 0);
    check("abort_out_bin", int'(out_bin), 0);
    check("abort_rd_en", int'(rd_en_vec), 0);
    check("abort_rd_add", int'(rd_add), 0);
    check("abort_busy_done", int'({busy, done}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid || busy || done || (rd_en_vec != '0)) stale++;
    end
    check("post_reset_quiet", stale, 0);
    run_event(mk(0, 0, 0, 2, 0, 0, 0, 1, 4, 7, 6, 0), 6);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vm_proj_reader.md
VM_PROJ_READER -- requirements
Module: vm_proj_reader

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 2, giving cycles from a read-enable cycle to the end of the cycle in which rd_data is sampled.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO depth in entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to read one event; it is sampled only in IDLE.
REQ-006 The block SHALL have ports nent_phi1z1, nent_phi1z2, nent_phi2z1, nent_phi2z2, nent_phi3z1 and nent_phi3z2, each input, 9 bits: entry count per VM bin, latched on start.
REQ-007 The block SHALL have port rd_add, output, 9 bits: the shared registered read address.
REQ-008 The block SHALL have ports rd_en_phi1z1 through rd_en_phi3z2, six ports, each output, 1 bit: registered per-memory read enable.
REQ-009 The block SHALL have ports rd_data_phi1z1 through rd_data_phi3z2, six ports, each input, 13 bits: VM memory read data in the format {index[5:0], phi[2:0], z[3:0]}.
REQ-010 The block SHALL have port vm_projection_out, output, 13 bits: the FIFO head data, passed through unmodified.
REQ-011 The block SHALL have port out_bin, output, 3 bits: the source bin of the FIFO head, 0..5 in the order phi1z1, phi1z2, phi2z1, phi2z2, phi3z1, phi3z2.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accept; a handshake occurs when out_valid and out_ready are both high.
REQ-014 The block SHALL have port busy, output, 1 bit: the FSM is in ISSUE or DRAIN.
REQ-015 The block SHALL have port done, output, 1 bit: a one-cycle pulse at event completion.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE, with these transitions:
- IDLE to ISSUE on start.
- ISSUE to DRAIN after the final read is issued, or immediately if all counts are 0.
- DRAIN to DONE when in-flight count is 0, the FIFO is empty and no capture occurs this cycle.
- DONE to IDLE unconditionally.
REQ-017 On start in IDLE the block SHALL latch all six counts, set the bin pointer to the first non-empty bin and set the address to 0.
REQ-018 In ISSUE the block SHALL issue one read per cycle when credit permits: rd_en of the current bin high and rd_add equal to the current address.
- Addresses run 0 to count-1 within a bin.
- Bins are visited in ascending order.
REQ-019 Empty bins SHALL be skipped with zero bubble cycles, so the cycle after a bin's last read issues address 0 of the next non-empty bin.
REQ-020 At most one rd_en SHALL be high in any cycle; all rd_en SHALL be low outside issue cycles.
REQ-021 Credit rule: a read SHALL issue only if FIFO occupancy plus in-flight reads, both counted at the start of the cycle, is less than FIFO_DEPTH.
REQ-022 In-flight tracking SHALL use an RD_LATENCY-deep valid/bin shift register; data SHALL be captured into the FIFO from the tagged bin's rd_data at the end of cycle k+RD_LATENCY.
REQ-023 The FIFO SHALL be show-ahead, with out_valid and head data registered.
- Simultaneous capture and handshake SHALL leave occupancy unchanged.
- The FIFO SHALL never overflow; the credit rule guarantees this.
REQ-024 With out_ready held high, sustained throughput SHALL be one entry per cycle, including across bin boundaries.
REQ-025 Minimum latency SHALL be: start sampled at edge T, first rd_en in cycle T+1, first out_valid in cycle T+4 (RD_LATENCY=2).
REQ-026 Output order SHALL equal issue order, bin-major then ascending address.
REQ-027 start SHALL be ignored in ISSUE, DRAIN and DONE, and count inputs SHALL be ignored after latching.
REQ-028 A count of 511 SHALL issue addresses 0..510, with no counter wrap.
REQ-029 done SHALL be high only in DONE, exactly one cycle per accepted start; busy SHALL be low in IDLE and DONE.

Reset
REQ-030 While reset_n is low the block SHALL hold the following values:
- FSM = IDLE.
- rd_add = 0 and all rd_en = 0.
- The in-flight shift register and the FIFO cleared.
- out_valid = 0, vm_projection_out = 0 and out_bin = 0.
- busy = 0 and done = 0.
REQ-031 Reset mid-operation SHALL abort the event; data returning from reads issued before reset SHALL be discarded; operation resumes on the first start after release.

Verification
REQ-032 The bench SHALL cover: nent_phi1z1=3, other counts 0, out_ready=1, start at T -> rd_en_phi1z1 with rd_add 0,1,2 in cycles T+1..T+3; out_valid with out_bin=0 in cycles T+4..T+6; done in T+8.
REQ-033 The bench SHALL cover: all counts 0 -> no rd_en; busy in cycles T+1..T+2; done in cycle T+3.
REQ-034 The bench SHALL cover: nent_phi1z2=2, nent_phi3z2=2, others 0 -> reads issue in four consecutive cycles (bin1 addresses 0,1 then bin5 addresses 0,1); outputs in order with out_bin 1,1,5,5.
REQ-035 The bench SHALL cover: nent_phi2z1=10, out_ready=0 for 20 cycles then 1 -> issue stalls with occupancy plus in-flight equal to 4; no overflow; all 10 entries delivered in order.
REQ-036 The bench SHALL cover: reset_n pulsed low during ISSUE of a 5-entry event -> outputs cleared immediately; no stale out_valid after release; a subsequent 2-entry event delivers exactly 2 entries.
REQ-037 The bench SHALL cover: start asserted again while busy -> ignored; exactly one done pulse.
